// File: rtl/encode_pkg.sv
// Shared types and constants for the RV32 instruction encoder.
package encode_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_LI = 3'd6
  } fmt_t;

  typedef enum logic {
    IDLE  = 1'b0,
    LI_LO = 1'b1
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_CALCI  = 7'b0010011;
  localparam logic [6:0] OP_CALC   = 7'b0110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // True when bits [31:w-1] are all equal, i.e. v is a sign-extended w-bit value.
  function automatic logic fits_signed(input logic [31:0] v, input int w);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << (w - 1);
    return ((v & mask) == mask) || ((v & mask) == 32'd0);
  endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// imm_pack: combinational field/immediate packer for the R/I/S/B/U/J formats.
// With RANGE_CHECK_EN defined, unrepresentable immediates yield NOP_WORD and range_err.
module imm_pack
  import encode_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP
) (
  input  fmt_t        fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_err
);

  logic [31:0] raw;

  always_comb begin
    raw = NOP_WORD;
    case (fmt)
      FMT_R:   raw = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   raw = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   raw = {imm[31:12], rd, opcode};
      FMT_J:   raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: raw = NOP_WORD;
    endcase
  end

`ifdef RANGE_CHECK_EN
  logic bad;

  always_comb begin
    bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: bad = ~fits_signed(imm, 12);
      FMT_B:        bad = ~fits_signed(imm, 13) | imm[0];
      FMT_J:        bad = ~fits_signed(imm, 21) | imm[0];
      FMT_U:        bad = |imm[11:0];
      default:      bad = 1'b0;
    endcase
  end

  assign word      = bad ? NOP_WORD : raw;
  assign range_err = bad;
`else
  // Bit 0 of B/J offsets is implied; without checking it is simply dropped.
  logic unused_imm_lsb;
  assign unused_imm_lsb = imm[0];
  assign word           = raw;
  assign range_err      = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32 encoder, valid/ready on both sides, LI expands to LUI+ADDI.
// Build option RANGE_CHECK_EN enables immediate range checking in imm_pack.
module instr_encoder
  import encode_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP,
  parameter bit          LI_OPT   = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  fmt_t        in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);
  // state | meaning
  // IDLE  | accepting requests; output register may hold a final beat
  // LI_LO | LUI beat on output, ADDI beat parked in lo_word

  state_t      state, state_nxt;
  logic        valid_nxt, last_nxt, err_nxt;
  logic [31:0] instr_nxt, lo_word, lo_word_nxt;
  logic [31:0] pack_word;
  logic        pack_err;
  logic        accept;
  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic [31:0] lui_word, addi_rd_word, addi_x0_word;

  imm_pack #(.NOP_WORD(NOP_WORD)) u_imm_pack (
    .fmt      (in_fmt),
    .opcode   (in_opcode),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .funct3   (in_funct3),
    .funct7   (in_funct7),
    .imm      (in_imm),
    .word     (pack_word),
    .range_err(pack_err)
  );

  // Rounding the upper part by imm[11] compensates for ADDI sign-extending lo.
  assign li_hi        = in_imm[31:12] + {19'd0, in_imm[11]};
  assign li_lo        = in_imm[11:0];
  assign lui_word     = {li_hi, in_rd, OP_LUI};
  assign addi_rd_word = {li_lo, in_rd, 3'b000, in_rd, OP_CALCI};
  assign addi_x0_word = {li_lo, 5'd0, 3'b000, in_rd, OP_CALCI};

  assign in_ready = (state == IDLE) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_nxt   = state;
    valid_nxt   = out_valid;
    instr_nxt   = out_instr;
    last_nxt    = out_last;
    err_nxt     = out_err;
    lo_word_nxt = lo_word;
    case (state)
      IDLE: begin
        if (accept) begin
          valid_nxt = 1'b1;
          if (in_fmt == FMT_LI) begin
            err_nxt = 1'b0;
            if (LI_OPT && (li_hi == 20'd0)) begin
              instr_nxt = addi_x0_word;
              last_nxt  = 1'b1;
            end else if (LI_OPT && (li_lo == 12'd0)) begin
              instr_nxt = lui_word;
              last_nxt  = 1'b1;
            end else begin
              instr_nxt   = lui_word;
              last_nxt    = 1'b0;
              lo_word_nxt = addi_rd_word;
              state_nxt   = LI_LO;
            end
          end else begin
            instr_nxt = pack_word;
            last_nxt  = 1'b1;
            err_nxt   = pack_err;
          end
        end else if (out_ready) begin
          valid_nxt = 1'b0;
        end
      end
      LI_LO: begin
        if (out_ready) begin
          instr_nxt = lo_word;
          last_nxt  = 1'b1;
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      lo_word   <= 32'd0;
    end else begin
      state     <= state_nxt;
      out_valid <= valid_nxt;
      out_instr <= instr_nxt;
      out_last  <= last_nxt;
      out_err   <= err_nxt;
      lo_word   <= lo_word_nxt;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder: scoreboard of expected beats plus immediate round-trip decode.
module tb_instr_encoder;
  import encode_pkg::*;

  localparam bit LI_OPT = 1'b1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  fmt_t        in_fmt = FMT_R;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_last, out_err;

  instr_encoder #(.NOP_WORD(NOP), .LI_OPT(LI_OPT)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_last(out_last), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        last;
    logic        err;
    logic        rt;
    fmt_t        fmt;
    logic [31:0] imm;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  bit    accepted = 1'b0;
  bit    prev_hold = 1'b0;
  logic [31:0] prev_instr = '0;
  logic        prev_last = 1'b0;

  logic        n_valid = 1'b0;
  fmt_t        n_fmt = FMT_R;
  logic [6:0]  n_op = '0, n_f7 = '0;
  logic [4:0]  n_rd = '0, n_rs1 = '0, n_rs2 = '0;
  logic [2:0]  n_f3 = '0;
  logic [31:0] n_imm = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] instr, input logic last, input logic err,
                               input logic rt, input fmt_t f, input logic [31:0] imm);
    beat_t b;
    b.instr = instr; b.last = last; b.err = err; b.rt = rt; b.fmt = f; b.imm = imm;
    return b;
  endfunction

  function automatic bit in_range(input fmt_t f, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (f)
      FMT_I, FMT_S: return (s >= -2048) && (s <= 2047);
      FMT_B:        return (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
      FMT_J:        return (s >= -1048576) && (s <= 1048575) && (imm[0] == 1'b0);
      FMT_U:        return (imm % 32'd4096) == 32'd0;
      default:      return 1'b1;
    endcase
  endfunction

  // Reference encoder built from field shifts/masks on the integer immediate.
  function automatic logic [31:0] enc(input fmt_t f, input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] imm);
    logic [31:0] o, d, a, s1, s2, fn;
    o = 32'(op); d = 32'(rd) << 7; fn = 32'(f3) << 12; s1 = 32'(rs1) << 15; s2 = 32'(rs2) << 20;
    case (f)
      FMT_R: a = o | d | fn | s1 | s2 | (32'(f7) << 25);
      FMT_I: a = o | d | fn | s1 | ((imm & 32'hFFF) << 20);
      FMT_S: a = o | ((imm & 32'h1F) << 7) | fn | s1 | s2 | (((imm >> 5) & 32'h7F) << 25);
      FMT_B: a = o | (((imm >> 11) & 32'd1) << 7) | (((imm >> 1) & 32'hF) << 8) | fn | s1 | s2
                 | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'd1) << 31);
      FMT_U: a = o | d | (imm & 32'hFFFF_F000);
      FMT_J: a = o | d | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'd1) << 20)
                 | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'd1) << 31);
      default: a = NOP;
    endcase
    return a;
  endfunction

  function automatic logic [31:0] extract(input fmt_t f, input logic [31:0] w);
    case (f)
      FMT_I:   return {{20{w[31]}}, w[31:20]};
      FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   return {w[31:12], 12'd0};
      FMT_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_push(input fmt_t f, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] hi, lo, lui, addi_rd, addi_x0;
    bit ok, rc;
    if (f == FMT_LI) begin
      hi      = (imm + 32'h800) >> 12;
      lo      = imm & 32'hFFF;
      lui     = (hi << 12) | (32'(rd) << 7) | 32'h37;
      addi_rd = (lo << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
      addi_x0 = (lo << 20) | (32'(rd) << 7) | 32'h13;
      if (LI_OPT && hi == 32'd0)      exp_q.push_back(mk(addi_x0, 1'b1, 1'b0, 1'b0, f, imm));
      else if (LI_OPT && lo == 32'd0) exp_q.push_back(mk(lui, 1'b1, 1'b0, 1'b0, f, imm));
      else begin
        exp_q.push_back(mk(lui, 1'b0, 1'b0, 1'b0, f, imm));
        exp_q.push_back(mk(addi_rd, 1'b1, 1'b0, 1'b0, f, imm));
      end
    end else begin
      ok = in_range(f, imm);
      rc = 1'b0;
`ifdef RANGE_CHECK_EN
      rc = 1'b1;
`endif
      if (rc && !ok) exp_q.push_back(mk(NOP, 1'b1, 1'b1, 1'b0, f, imm));
      else exp_q.push_back(mk(enc(f, op, rd, rs1, rs2, f3, f7, imm), 1'b1, 1'b0,
                              ok && (f != FMT_R), f, imm));
    end
  endtask

  // One cycle: drive at negedge, settle, check against scoreboard, record handshakes.
  task automatic step(input bit rdy);
    beat_t e;
    @(negedge clk);
    out_ready = rdy;
    in_valid = n_valid; in_fmt = n_fmt; in_opcode = n_op; in_rd = n_rd; in_rs1 = n_rs1;
    in_rs2 = n_rs2; in_funct3 = n_f3; in_funct7 = n_f7; in_imm = n_imm;
    #1;
    accepted = 1'b0;
    if (prev_hold) begin
      chk("hold_instr", out_instr, prev_instr);
      chk("hold_last", 32'(out_last), 32'(prev_last));
    end
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || (exp_q.size() == 1 && rdy)));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_beat", 32'(out_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("instr", out_instr, e.instr);
        chk("last", 32'(out_last), 32'(e.last));
        chk("err", 32'(out_err), 32'(e.err));
        if (e.rt) chk("roundtrip", extract(e.fmt, out_instr), e.imm);
      end
    end
    if (in_valid && in_ready) begin
      accepted = 1'b1;
      model_push(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
    end
    prev_hold  = out_valid && !out_ready;
    prev_instr = out_instr;
    prev_last  = out_last;
  endtask

  task automatic send(input fmt_t f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input int rdy_pct);
    n_valid = 1'b1; n_fmt = f; n_op = op; n_rd = rd; n_rs1 = rs1; n_rs2 = rs2;
    n_f3 = f3; n_f7 = f7; n_imm = imm;
    for (int i = 0; i < 60; i++) begin
      step(int'($urandom_range(0, 99)) < rdy_pct);
      if (accepted) break;
    end
    if (!accepted) chk("accept_timeout", 32'(accepted), 32'd1);
    n_valid = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [31:0] instr, input logic last, input logic err);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_instr"}, out_instr, instr);
    chk({tag, "_last"}, 32'(out_last), 32'(last));
    chk({tag, "_err"}, 32'(out_err), 32'(err));
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    send(FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 0);
    step(1'b0); peek("vec_i", 32'hFFF0_0093, 1'b1, 1'b0); step(1'b1);

    send(FMT_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 0);
    step(1'b0); peek("vec_b", 32'hFE20_8EE3, 1'b1, 1'b0); step(1'b1);

    send(FMT_LI, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF, 0);
    step(1'b0); peek("li_beat0", 32'h1234_62B7, 1'b0, 1'b0);
    step(1'b0); step(1'b0); step(1'b0);
    peek("li_held", 32'h1234_62B7, 1'b0, 1'b0);
    chk("li_held_ready", 32'(in_ready), 32'd0);
    step(1'b1);
    step(1'b0); peek("li_beat1", 32'hFFF2_8293, 1'b1, 1'b0); step(1'b1);

    send(FMT_LI, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_07FF, 0);
    step(1'b0); peek("li_single", 32'h7FF0_0293, 1'b1, 1'b0); step(1'b1);

    send(FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 0);
    step(1'b0);
`ifdef RANGE_CHECK_EN
    peek("i_range", 32'h0000_0013, 1'b1, 1'b1);
`else
    peek("i_trunc", 32'h8000_0093, 1'b1, 1'b0);
`endif
    step(1'b1);

    send(FMT_LI, 7'd0, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000, 100);
    step(1'b1);

    send(FMT_LI, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF, 0);
    step(1'b0); peek("rst_pend", 32'h1234_62B7, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_last", 32'(out_last), 32'd0);
    exp_q.delete();
    prev_hold = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step(1'b1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step(1'b1); step(1'b1); step(1'b1);

    for (int t = 0; t < 400; t++) begin
      fmt_t        f;
      logic [31:0] imm;
      f   = fmt_t'($urandom_range(0, 6));
      imm = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        case (f)
          FMT_I, FMT_S: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
          FMT_B:        imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
          FMT_J:        imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
          FMT_U:        imm = imm & 32'hFFFF_F000;
          FMT_LI:       imm = ($urandom_range(0, 1) != 0) ? (imm & 32'hFFFF_F000)
                                                          : (32'($urandom_range(0, 4095)) - 32'd2048);
          default:      ;
        endcase
      end
      send(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
           7'($urandom), imm, 70);
      if ($urandom_range(0, 4) == 0) step($urandom_range(0, 1) != 0);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b1);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
